// File: rtl/cgra_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cgra_cfg_sequencer
// Purpose  : Turns a compact command stream into CGRA Interconnect
//            configuration bus traffic. It covers bitstream write, readback
//            compare, flush pulses, SRAM prefill, SRAM readback and stall
//            control.
// Options  : CFG_SEQ_CHECK_EN builds the CHECK comparator and the mismatch
//            counter. Without it, CHECK behaves as READ and mismatch_cnt is 0.
// Ports    : clk, reset                          - clock, sync active-high reset
//            cmd_valid/ready, cmd_op/addr/data/len - command handshake
//            rsp_valid/ready, rsp_data/err        - response handshake
//            config_config_addr/data, config_read/write,
//            read_config_data                     - CGRA configuration bus
//            stall                                - CGRA stall lanes
//            mismatch_cnt                         - saturating CHECK mismatches
// Revision : 1.0 - initial release
// ============================================================================
module cgra_cfg_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int STALL_W   = 4,
    parameter int RD_LAT    = 1,
    parameter int FLUSH_LEN = 2,
    parameter int IDX_LSB   = 24,
    parameter int SUB_WORDS = 2,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [CNT_W-1:0]    cmd_len,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   config_config_addr,
    output logic [DATA_W-1:0]   config_config_data,
    output logic                config_read,
    output logic                config_write,
    input  logic [DATA_W-1:0]   read_config_data,
    output logic [STALL_W-1:0]  stall,
    output logic [15:0]         mismatch_cnt
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_WR     = 3'd1;
    localparam logic [2:0] c_S_RD     = 3'd2;
    localparam logic [2:0] c_S_RSP    = 3'd3;
    localparam logic [2:0] c_S_FL_ON  = 3'd4;
    localparam logic [2:0] c_S_FL_GAP = 3'd5;
    localparam logic [2:0] c_S_FL_OFF = 3'd6;

    localparam logic [2:0] c_OP_WRITE    = 3'd0;
    localparam logic [2:0] c_OP_CHECK    = 3'd1;
    localparam logic [2:0] c_OP_READ     = 3'd2;
    localparam logic [2:0] c_OP_FILL     = 3'd3;
    localparam logic [2:0] c_OP_READBACK = 3'd4;
    localparam logic [2:0] c_OP_FLUSH    = 3'd5;
    localparam logic [2:0] c_OP_STALL    = 3'd6;

    localparam int          c_SUB_SH   = $clog2(SUB_WORDS);
    localparam logic [15:0] c_RD_LAST  = 16'(RD_LAT - 1);
    localparam logic [15:0] c_FL_LAST  = 16'(FLUSH_LEN - 1);

    logic [2:0]         r_state, w_state_nxt;
    logic [2:0]         r_op, w_op_nxt;
    logic [15:0]        r_lat, w_lat_nxt;
    logic [CNT_W-1:0]   r_beat, w_beat_nxt;
    logic [CNT_W-1:0]   r_len, w_len_nxt;
    logic [ADDR_W-1:0]  r_base, w_base_nxt;
    logic [DATA_W-1:0]  r_ref, w_ref_nxt;
    logic               r_cmd_ready;
    logic [ADDR_W-1:0]  r_cfg_addr, w_cfg_addr_nxt;
    logic [DATA_W-1:0]  r_cfg_data, w_cfg_data_nxt;
    logic               r_cfg_rd, w_cfg_rd_nxt;
    logic               r_cfg_wr, w_cfg_wr_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]  r_rsp_data, w_rsp_data_nxt;
    logic               r_rsp_err, w_rsp_err_nxt;
    logic [STALL_W-1:0] r_stall, w_stall_nxt;
    logic               w_mis_inc;

    logic [CNT_W-1:0]   w_beat_inc;
    logic [ADDR_W-1:0]  w_idx;
    logic [ADDR_W-1:0]  w_beat_addr;

    // Address of the following beat. Every SUB_WORDS beats share one SRAM
    // index, and the index sits at IDX_LSB. The add wraps at 2^ADDR_W.
    always_comb begin
        w_beat_inc  = r_beat + 1'b1;
        w_idx       = ADDR_W'(w_beat_inc >> c_SUB_SH);
        w_beat_addr = r_base + (w_idx << IDX_LSB);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_lat_nxt       = r_lat;
        w_beat_nxt      = r_beat;
        w_len_nxt       = r_len;
        w_base_nxt      = r_base;
        w_ref_nxt       = r_ref;
        w_cfg_addr_nxt  = r_cfg_addr;
        w_cfg_data_nxt  = r_cfg_data;
        w_cfg_rd_nxt    = 1'b0;
        w_cfg_wr_nxt    = 1'b0;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;
        w_stall_nxt     = r_stall;
        w_mis_inc       = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (cmd_valid) begin
                    w_op_nxt   = cmd_op;
                    w_base_nxt = cmd_addr;
                    w_ref_nxt  = cmd_data;
                    w_beat_nxt = '0;
                    w_len_nxt  = cmd_len;
                    case (cmd_op)
                        c_OP_WRITE, c_OP_FILL: begin
                            // A single WRITE is a one-beat FILL.
                            if (cmd_op == c_OP_WRITE) w_len_nxt = CNT_W'(1);
                            if (cmd_op == c_OP_WRITE || cmd_len != '0) begin
                                w_state_nxt    = c_S_WR;
                                w_cfg_wr_nxt   = 1'b1;
                                w_cfg_addr_nxt = cmd_addr;
                                w_cfg_data_nxt = cmd_data;
                            end
                        end
                        c_OP_CHECK, c_OP_READ, c_OP_READBACK: begin
                            if (cmd_op != c_OP_READBACK) w_len_nxt = CNT_W'(1);
                            if (cmd_op != c_OP_READBACK || cmd_len != '0) begin
                                w_state_nxt    = c_S_RD;
                                w_cfg_rd_nxt   = 1'b1;
                                w_cfg_addr_nxt = cmd_addr;
                                w_lat_nxt      = c_RD_LAST;
                            end
                        end
                        c_OP_FLUSH: begin
                            w_state_nxt    = c_S_FL_ON;
                            w_cfg_wr_nxt   = 1'b1;
                            w_cfg_addr_nxt = cmd_addr;
                            w_cfg_data_nxt = cmd_data;
                            w_lat_nxt      = c_FL_LAST;
                        end
                        c_OP_STALL: begin
                            w_stall_nxt = cmd_data[STALL_W-1:0];
                        end
                        default: begin
                            w_state_nxt     = c_S_RSP;
                            w_rsp_valid_nxt = 1'b1;
                            w_rsp_data_nxt  = '0;
                            w_rsp_err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            c_S_WR: begin
                if (w_beat_inc == r_len) begin
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_beat_nxt     = w_beat_inc;
                    w_cfg_addr_nxt = w_beat_addr;
                    w_cfg_wr_nxt   = 1'b1;
                end
            end
            c_S_RD: begin
                if (r_lat == '0) begin
                    w_state_nxt     = c_S_RSP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = read_config_data;
`ifdef CFG_SEQ_CHECK_EN
                    w_mis_inc       = (r_op == c_OP_CHECK) && (read_config_data != r_ref);
                    w_rsp_err_nxt   = w_mis_inc;
`else
                    w_rsp_err_nxt   = 1'b0;
`endif
                end else begin
                    w_lat_nxt    = r_lat - 1'b1;
                    w_cfg_rd_nxt = 1'b1;
                end
            end
            c_S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (r_op == c_OP_READBACK && w_beat_inc != r_len) begin
                        w_state_nxt    = c_S_RD;
                        w_beat_nxt     = w_beat_inc;
                        w_cfg_addr_nxt = w_beat_addr;
                        w_cfg_rd_nxt   = 1'b1;
                        w_lat_nxt      = c_RD_LAST;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end
            c_S_FL_ON: begin
                if (r_lat == '0) begin
                    w_state_nxt = c_S_FL_GAP;
                end else begin
                    w_lat_nxt    = r_lat - 1'b1;
                    w_cfg_wr_nxt = 1'b1;
                end
            end
            c_S_FL_GAP: begin
                // The de-assert word keeps the upper half of the flush word
                // and clears the low 16 bits.
                w_state_nxt    = c_S_FL_OFF;
                w_cfg_wr_nxt   = 1'b1;
                w_cfg_data_nxt = {r_ref[DATA_W-1:16], 16'h0};
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_op        <= '0;
            r_lat       <= '0;
            r_beat      <= '0;
            r_len       <= '0;
            r_base      <= '0;
            r_ref       <= '0;
            r_cmd_ready <= 1'b1;
            r_cfg_addr  <= '0;
            r_cfg_data  <= '0;
            r_cfg_rd    <= 1'b0;
            r_cfg_wr    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_stall     <= '1;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_lat       <= w_lat_nxt;
            r_beat      <= w_beat_nxt;
            r_len       <= w_len_nxt;
            r_base      <= w_base_nxt;
            r_ref       <= w_ref_nxt;
            r_cmd_ready <= (w_state_nxt == c_S_IDLE);
            r_cfg_addr  <= w_cfg_addr_nxt;
            r_cfg_data  <= w_cfg_data_nxt;
            r_cfg_rd    <= w_cfg_rd_nxt;
            r_cfg_wr    <= w_cfg_wr_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_stall     <= w_stall_nxt;
        end
    end

`ifdef CFG_SEQ_CHECK_EN
    logic [15:0] r_mismatch;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mismatch <= '0;
        end else if (w_mis_inc && r_mismatch != 16'hFFFF) begin
            r_mismatch <= r_mismatch + 16'd1;
        end
    end
    assign mismatch_cnt = r_mismatch;
`else
    assign mismatch_cnt = 16'h0;
`endif

    assign cmd_ready          = r_cmd_ready;
    assign rsp_valid          = r_rsp_valid;
    assign rsp_data           = r_rsp_data;
    assign rsp_err            = r_rsp_err;
    assign config_config_addr = r_cfg_addr;
    assign config_config_data = r_cfg_data;
    assign config_read        = r_cfg_rd;
    assign config_write       = r_cfg_wr;
    assign stall              = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_cgra_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cgra_cfg_sequencer
// Purpose  : Directed self-checking bench for cgra_cfg_sequencer, built with
//            RD_LAT=5. A small bus model drives read_config_data, and a
//            monitor records every write beat together with its cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cgra_cfg_sequencer;

    localparam int RD_LAT = 5;
`ifdef CFG_SEQ_CHECK_EN
    localparam logic c_CHK = 1'b1;
`else
    localparam logic c_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [15:0] cmd_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] config_config_addr;
    logic [31:0] config_config_data;
    logic        config_read;
    logic        config_write;
    logic [31:0] read_config_data;
    logic [3:0]  stall;
    logic [15:0] mismatch_cnt;

    logic        mem_mode = 1'b0;
    logic [31:0] rd_val = '0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t wq[$];
    int  cyc = 0;
    int  rd_cycles = 0;
    int  overlap = 0;

    always #5 clk = ~clk;

    // In memory mode the bus answers with a value derived from the address.
    assign read_config_data = mem_mode ? (config_config_addr ^ 32'h5A5A_0000) : rd_val;

    cgra_cfg_sequencer #(
        .RD_LAT(RD_LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_addr           (cmd_addr),
        .cmd_data           (cmd_data),
        .cmd_len            (cmd_len),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_data           (rsp_data),
        .rsp_err            (rsp_err),
        .config_config_addr (config_config_addr),
        .config_config_data (config_config_data),
        .config_read        (config_read),
        .config_write       (config_write),
        .read_config_data   (read_config_data),
        .stall              (stall),
        .mismatch_cnt       (mismatch_cnt)
    );

    // Record the cycle that is just ending.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (config_write) wq.push_back('{config_config_addr, config_config_data, cyc});
        if (config_read) rd_cycles = rd_cycles + 1;
        if (config_read && config_write) overlap = overlap + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [15:0] len);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready_timeout", 64'(t < 2000), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_len   = len;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(t < 2000), 64'd1);
    endtask

    // Returns the number of negedges that passed before rsp_valid was seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        check("rsp_timeout", 64'(lat < 200), 64'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        int          nq;
        logic [31:0] exp_a;

        // Reset
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_stall", 64'(stall), 64'hF);
        check("rst_write", 64'(config_write), 64'd0);
        check("rst_read", 64'(config_read), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mismatch", 64'(mismatch_cnt), 64'd0);

        // STALL
        send(3'd6, 32'h0, 32'h0000_0005, 16'd0);
        @(negedge clk);
        check("stall_val", 64'(stall), 64'h5);
        check("stall_no_bus", 64'(config_write | config_read), 64'd0);

        // WRITE
        wq.delete();
        send(3'd0, 32'h0000_0302, 32'h001C_0000, 16'd0);
        @(negedge clk);
        check("wr_strobe", 64'(config_write), 64'd1);
        check("wr_addr", 64'(config_config_addr), 64'h0000_0302);
        check("wr_data", 64'(config_config_data), 64'h001C_0000);
        @(negedge clk);
        check("wr_done", 64'(config_write), 64'd0);
        check("wr_ready_back", 64'(cmd_ready), 64'd1);
        check("wr_count", 64'(wq.size()), 64'd1);

        // CHECK, data matches
        rd_val    = 32'h001C_0000;
        rd_cycles = 0;
        send(3'd1, 32'h0000_0302, 32'h001C_0000, 16'd0);
        wait_rsp(lat);
        check("chk_latency", 64'(lat), 64'(RD_LAT));
        check("chk_rd_cycles", 64'(rd_cycles), 64'(RD_LAT));
        check("chk_ok_data", 64'(rsp_data), 64'h001C_0000);
        check("chk_ok_err", 64'(rsp_err), 64'd0);
        handshake();
        @(negedge clk);
        check("chk_ok_mis", 64'(mismatch_cnt), 64'd0);
        check("chk_rsp_drop", 64'(rsp_valid), 64'd0);

        // CHECK, data differs
        rd_val = 32'h001C_0001;
        send(3'd1, 32'h0000_0302, 32'h001C_0000, 16'd0);
        wait_rsp(lat);
        check("chk_bad_data", 64'(rsp_data), 64'h001C_0001);
        check("chk_bad_err", 64'(rsp_err), 64'(c_CHK));
        handshake();
        @(negedge clk);
        check("chk_bad_mis", 64'(mismatch_cnt), 64'(c_CHK));

        // READ never flags an error
        rd_val = 32'hDEAD_BEEF;
        send(3'd2, 32'h0000_0400, 32'h0, 16'd0);
        wait_rsp(lat);
        check("rd_data", 64'(rsp_data), 64'hDEAD_BEEF);
        check("rd_err", 64'(rsp_err), 64'd0);
        handshake();

        // Illegal op
        send(3'd7, 32'h0, 32'h0, 16'd0);
        wait_rsp(lat);
        check("ill_latency", 64'(lat), 64'd0);
        check("ill_data", 64'(rsp_data), 64'd0);
        check("ill_err", 64'(rsp_err), 64'd1);
        handshake();

        // FILL of 512 words
        wait_idle("pre_fill_idle");
        wq.delete();
        send(3'd3, 32'h0001_0201, 32'h0000_0099, 16'd512);
        wait_idle("fill_idle");
        check("fill_count", 64'(wq.size()), 64'd512);
        if (wq.size() == 512) begin
            check("fill_span", 64'(wq[511].cyc - wq[0].cyc), 64'd511);
            for (int i = 0; i < 512; i++) begin
                exp_a = 32'h0001_0201 + (32'(i / 2) << 24);
                check("fill_addr", 64'(wq[i].addr), 64'(exp_a));
                check("fill_data", 64'(wq[i].data), 64'h99);
            end
        end

        // FILL with zero length
        wq.delete();
        send(3'd3, 32'h0000_1000, 32'h1, 16'd0);
        @(negedge clk);
        check("fill0_ready", 64'(cmd_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("fill0_no_wr", 64'(wq.size()), 64'd0);

        // FLUSH
        wq.delete();
        send(3'd5, 32'h0000_0100, 32'h001C_7E00, 16'd0);
        wait_idle("flush_idle");
        check("flush_count", 64'(wq.size()), 64'd3);
        if (wq.size() == 3) begin
            check("flush_d0", 64'(wq[0].data), 64'h001C_7E00);
            check("flush_d1", 64'(wq[1].data), 64'h001C_7E00);
            check("flush_d2", 64'(wq[2].data), 64'h001C_0000);
            check("flush_c1", 64'(wq[1].cyc - wq[0].cyc), 64'd1);
            check("flush_c2", 64'(wq[2].cyc - wq[0].cyc), 64'd3);
        end
        check("stall_kept", 64'(stall), 64'h5);

        // READBACK, 4 beats with rsp_ready held off
        mem_mode  = 1'b1;
        rd_cycles = 0;
        send(3'd4, 32'h0000_0010, 32'h0, 16'd4);
        for (int b = 0; b < 4; b++) begin
            wait_rsp(lat);
            exp_a = (32'h0000_0010 + (32'(b / 2) << 24)) ^ 32'h5A5A_0000;
            for (int k = 0; k < 3; k++) begin
                check("rb_valid_hold", 64'(rsp_valid), 64'd1);
                check("rb_data", 64'(rsp_data), 64'(exp_a));
                @(negedge clk);
            end
            handshake();
            if (b < 3) begin
                @(negedge clk);
                check("rb_next_rd", 64'(config_read), 64'd1);
            end
        end
        wait_idle("rb_idle");
        check("rb_rd_cycles", 64'(rd_cycles), 64'(4 * RD_LAT));
        mem_mode = 1'b0;

        // Reset in the middle of a FILL
        wq.delete();
        send(3'd3, 32'h0000_2000, 32'h0000_0077, 16'd100);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mrst_write", 64'(config_write), 64'd0);
        check("mrst_stall", 64'(stall), 64'hF);
        check("mrst_ready", 64'(cmd_ready), 64'd1);
        check("mrst_rsp", 64'(rsp_valid), 64'd0);
        check("mrst_mis", 64'(mismatch_cnt), 64'd0);
        nq = wq.size();
        check("mrst_partial", 64'(nq < 100), 64'd1);
        repeat (20) @(negedge clk);
        check("mrst_no_more", 64'(wq.size()), 64'(nq));
        send(3'd0, 32'h0000_0ABC, 32'h0000_1234, 16'd0);
        wait_idle("post_rst_idle");
        check("post_rst_count", 64'(wq.size()), 64'(nq + 1));
        if (wq.size() == nq + 1) begin
            check("post_rst_addr", 64'(wq[nq].addr), 64'h0ABC);
            check("post_rst_data", 64'(wq[nq].data), 64'h1234);
        end

        check("rd_wr_overlap", 64'(overlap), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cgra_cfg_sequencer.md
# cgra_cfg_sequencer

Hardware sequencer that drives the CGRA `Interconnect` configuration bus (`config_*`, `read_config_data`, `stall`) from a compact command stream. It replaces hand-sequenced host traffic for bitstream load, bitstream readback check, flush pulses, SRAM prefill and SRAM readback. It sits between the management-side command source and the CGRA. It is parametrised in bus width, stall width, read latency, flush length and SRAM word packing.

## Interface
- `ADDR_W`, 32, config address width
- `DATA_W`, 32, config data width (≥17)
- `STALL_W`, 4, stall lanes (one per config column group)
- `RD_LAT`, 1, cycles `config_read` is held before `read_config_data` is sampled (≥1; SRAM reads use 5)
- `FLUSH_LEN`, 2, cycles the flush-assert word is held on the bus
- `IDX_LSB`, 24, LSB of the SRAM index field in the address
- `SUB_WORDS`, 2, config words per SRAM index (power of 2)
- `CNT_W`, 16, burst length width
- `clk  in  1  clock`
- `reset  in  1  synchronous, active-high reset`
- `cmd_valid  in  1`; `cmd_ready  out  1`: command handshake
- `cmd_op  in  3`: 0 WRITE, 1 CHECK, 2 READ, 3 FILL, 4 READBACK, 5 FLUSH, 6 STALL, 7 illegal
- `cmd_addr  in  ADDR_W`; `cmd_data  in  DATA_W`; `cmd_len  in  CNT_W`: command operands
- `rsp_valid  out  1`; `rsp_ready  in  1`: response handshake
- `rsp_data  out  DATA_W`; `rsp_err  out  1`: read data; mismatch/illegal flag
- `config_config_addr  out  ADDR_W`; `config_config_data  out  DATA_W`
- `config_read  out  1`; `config_write  out  1`
- `read_config_data  in  DATA_W`: CGRA readback bus
- `stall  out  STALL_W`: CGRA stall
- `mismatch_cnt  out  16`: saturating count of CHECK mismatches

## Operation
- States: IDLE, WR, RD, RSP, FL_ON, FL_GAP, FL_OFF.
- `cmd_ready`=1 only in IDLE. A command is accepted on a `cmd_valid & cmd_ready` edge.
- WRITE: WR for 1 cycle with `config_write`=1, addr/data = operands. Then IDLE.
- READ/CHECK: RD for RD_LAT cycles with `config_read`=1. `read_config_data` is captured at the last RD edge, then the block goes to RSP.
- CHECK: `rsp_err` = (captured ≠ `cmd_data`). On mismatch, `mismatch_cnt` increments and saturates at 16'hFFFF.
- FILL: `cmd_len` back-to-back write cycles. Beat i uses address `cmd_addr + ((i / SUB_WORDS) << IDX_LSB)` (modulo 2^ADDR_W) and data `cmd_data`. No response.
- READBACK: `cmd_len` beats with the same address rule. Each beat does RD then RSP. The next beat starts only after the response handshake.
- FLUSH: FL_ON holds a write of `cmd_data` for FLUSH_LEN cycles, FL_GAP is 1 idle cycle, and FL_OFF writes `{cmd_data[DATA_W-1:16],16'h0}` for 1 cycle.
- STALL: `stall` <= `cmd_data[STALL_W-1:0]` at the accept edge. There is no bus activity.
- Illegal op: goes to RSP with `rsp_data`=0 and `rsp_err`=1.
- FILL/READBACK with `cmd_len`=0: no bus activity, no response, back to IDLE.
- RSP: `rsp_valid` is held, and `rsp_data`/`rsp_err` are stable until `rsp_ready`.
- `config_read` and `config_write` are never high together. `stall` is never changed by any op other than STALL.

## Timing
- Reset values: `stall` all ones (CGRA stalled); every other output is 0; state IDLE; `cmd_ready`=1 in the first cycle after reset.
- Reset asserted mid-operation: the next edge forces reset values. The in-flight command is dropped, no response is issued, and `mismatch_cnt` is cleared.
- All outputs are registered. A command accepted at edge N drives the bus from cycle N+1.
- WRITE: bus active in cycle N+1; `cmd_ready` is high again in cycle N+2.
- READ: `config_read` is high in cycles N+1..N+RD_LAT; `rsp_valid` is high from cycle N+RD_LAT+1.
- FILL of L words occupies cycles N+1..N+L, one word per cycle.
- FLUSH occupies FLUSH_LEN+2 cycles after accept.
- Response handshake at edge M: for READBACK, the next beat's `config_read` starts in cycle M+1; otherwise the block returns to IDLE.

## Configuration
- `CFG_SEQ_CHECK_EN` defined: CHECK compares the captured data, drives `rsp_err`, and updates `mismatch_cnt`.
- Not defined: CHECK behaves exactly as READ, `rsp_err` is 0 except for illegal ops, `mismatch_cnt` is tied to 0, and the comparator and counter are not built.

## Test plan
- Reset check: reset 3 cycles -> `stall`=4'hF, `config_write`=`config_read`=0, `cmd_ready`=1.
- WRITE addr 0x0000_0302, data 0x001C_0000 -> exactly one `config_write` cycle carrying those values. CHECK on the same address with a model returning 0x001C_0000 -> `rsp_err`=0. The same CHECK with the model returning 0x001C_0001 -> `rsp_err`=1 and `mismatch_cnt`=1.
- FILL addr 0x0001_0201, data 0x99, len 512 -> 512 consecutive writes; addresses 0x0001_0201, 0x0001_0201, 0x0101_0201, … 0xFF01_0201; data always 0x99.
- FLUSH data 0x001C_7E00 -> 2 cycles writing 0x001C_7E00, 1 idle cycle, 1 cycle writing 0x001C_0000.
- READBACK len 4 with RD_LAT=5 and `rsp_ready` held low 3 cycles per beat -> 4 responses in order; `rsp_data` stable while `rsp_valid`=1 and `rsp_ready`=0; `config_read` held 5 cycles per beat.
- Reset asserted in the middle of a FILL of 100 words -> bus idle on the next cycle, `stall`=4'hF, no further writes, and the next command is accepted normally.
